vpu_operand_fetch: RTL and testbench
====================================

# vpu_operand_fetch

Operand-fetch stage between the VPU request FIFO and the vector lanes. Accepts one 136-bit `vpu_h2d_req_instr_t` at a time and decodes its opcode into a source-operand count. Issues one SRAM read per source port, captures the 512-bit rows, then streams them to the lanes as `EXEC_CNT` (=2) beats of `DWIDTH_PER_EXEC` (=256) bits per operand. Destination address and opcode travel with each beat for the downstream execute/writeback stages.

## Interface
- `SRC_CNT`, default `SRC_OPERAND_CNT` (3): read ports / operand slots.
- `ROW_W`, default `SRAM_DATA_WIDTH` (512): SRAM row width.
- `BEAT_W`, default `DWIDTH_PER_EXEC` (256): lane beat width; `ROW_W/BEAT_W` = `EXEC_CNT` = 2.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid_i`  in  1  instruction offered.
- `instr_ready_o`  out  1  block can accept.
- `instr_i`  in  136  `vpu_h2d_req_instr_t`.
- `rd_en_o`  out  `SRC_CNT`  per-port read strobe.
- `rd_bank_o`  out  `SRC_CNT`×2  per-port bank id.
- `rd_addr_o`  out  `SRC_CNT`×10  per-port row address.
- `rd_data_i`  in  `SRC_CNT`×512  read data, valid exactly 1 cycle after `rd_en_o`.
- `op_valid_o`  out  1  beat valid.
- `op_ready_i`  in  1  lane accepts beat.
- `op_data_o`  out  `SRC_CNT`×256  operand beats; slot i = src i.
- `op_src_mask_o`  out  3  valid-slot mask (1→3'b001, 2→3'b011, 3→3'b111).
- `op_exec_idx_o`  out  1  beat index.
- `op_last_o`  out  1  final beat of instruction.
- `op_opcode_o`  out  8  latched opcode.
- `op_dst_o`  out  32  latched dst0 address.
- `illegal_o`  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Opcode→src count:
  - 2 sources: FADD, FSUB, FMUL, FDIV, FMAX2, FAVG2.
  - 3 sources: FADD3, FMAX3, FAVG3.
  - 1 source: FSUM, FMAX, FEXP, FSQRT, FRECIP.
  - Any other value is illegal.
- Address split per source address: bank = `addr[10:9]`, row = `addr[20:11]`. Bits [8:0] and [31:21] are ignored.
- FSM states IDLE, READ, CAPT, SEND:
  - IDLE: `instr_ready_o`=1. On `instr_valid_i` && ready, latch instr.
    - Legal opcode → READ.
    - Illegal opcode → pulse `illegal_o` next cycle, stay IDLE, no reads issued.
  - READ: `rd_en_o[i]`=1 for i < src count; bank/addr driven from the latched srcs. Unused ports drive en/bank/addr = 0. → CAPT.
  - CAPT: capture `rd_data_i` for enabled ports into a 3×512 buffer; unused slots are zeroed. → SEND, `exec_idx`=0.
  - SEND: `op_valid_o`=1.
    - `op_data_o[i]` = `buf[i][exec_idx*256 +: 256]` (beat 0 = elements 0–15).
    - `op_last_o` = (`exec_idx`==1).
    - On valid&&ready: if last → IDLE, else `exec_idx`++.
- Beat data and sideband stay stable while `op_valid_o`=1 and `op_ready_i`=0. No beat is dropped.

## Timing
- Reset values: `instr_ready_o`=1 (state IDLE); all other outputs 0; buffer and latched instr cleared.
- Accept at cycle T → `rd_en_o` at T+1 → data captured at T+2 → `op_valid_o` at T+3.
- With `op_ready_i` held high: beat 1 at T+4, IDLE at T+5, next accept at T+5. Peak rate is one instruction per 5 cycles.
- `instr_ready_o` is low in READ/CAPT/SEND; there is no overlap between instructions.
- Backpressure holds SEND indefinitely; `exec_idx` does not advance.
- `illegal_o` is high for exactly one cycle. Op outputs are unaffected.
- Reset asserted mid-operation: immediate return to IDLE. Outputs go to reset values; pending reads and beats are abandoned and never emitted.
- Identical bank/row across ports is legal. Conflict resolution belongs to the SRAM side.

## Structure
- Add to VPU_PKG:
  - `get_src_cnt(opcode)` function returning 0 for illegal opcodes.
  - `vpu_fetch_state_t` enum (IDLE/READ/CAPT/SEND).
- Reuse `get_bank_id`/`get_raddr` for the address split.
- No sub-module: decode is a package function; the FSM, buffer and beat mux live in one module.

## Test plan
- FADD (0x01), src0=0x0000_0A00, src1=0x0000_1200 → `rd_en_o`=3'b011; port0 bank 1 row 1, port1 bank 1 row 2; two beats with mask 3'b011 and slot 2 = 0; `op_last_o` on beat 1.
- FADD3 (0x05) with row data 0xAAAA…/0x5555…/0x1234… patterns → beat 0 = bits [255:0], beat 1 = bits [511:256] of each row; valid 3 cycles after accept.
- FEXP (0x0C) with `op_ready_i` low for 4 cycles in SEND → beat 0 held stable; rest of sequence unchanged after release.
- Opcode 0x00, then 0x0F → `illegal_o` pulses once each; no `rd_en_o`; `instr_ready_o` stays 1.
- Back-to-back FMUL instructions with ready high → second accepted exactly 5 cycles after the first.
- `rst_n` pulsed low during CAPT → `op_valid_o` never rises for that instruction; `instr_ready_o`=1 right after reset.

Source files
------------

// File: rtl/vpu_operand_fetch_pkg.sv
// Shared types and helpers for the VPU operand-fetch stage.
//   - Geometry localparams (source slots, SRAM row width, lane beat width).
//   - Instruction word layout (136 bits) and opcode encodings.
//   - Fetch FSM state type.
//   - Address split helpers (bank / row) and opcode -> source-count decode.
package vpu_operand_fetch_pkg;

    localparam int SRC_OPERAND_CNT = 3;
    localparam int SRAM_DATA_WIDTH = 512;
    localparam int DWIDTH_PER_EXEC = 256;
    localparam int EXEC_CNT        = SRAM_DATA_WIDTH / DWIDTH_PER_EXEC;
    localparam int BANK_W          = 2;
    localparam int RADDR_W         = 10;

    typedef enum logic [7:0] {
        OP_FADD   = 8'h01,
        OP_FSUB   = 8'h02,
        OP_FMUL   = 8'h03,
        OP_FDIV   = 8'h04,
        OP_FADD3  = 8'h05,
        OP_FMAX3  = 8'h06,
        OP_FAVG3  = 8'h07,
        OP_FMAX2  = 8'h08,
        OP_FAVG2  = 8'h09,
        OP_FSUM   = 8'h0A,
        OP_FMAX   = 8'h0B,
        OP_FEXP   = 8'h0C,
        OP_FSQRT  = 8'h0D,
        OP_FRECIP = 8'h0E
    } vpu_opcode_t;

    // Opcode kept as raw bits so undefined encodings can be carried and flagged.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] dst0;
        logic [31:0] src0;
        logic [31:0] src1;
        logic [31:0] src2;
    } vpu_h2d_req_instr_t;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_READ,
        FETCH_CAPT,
        FETCH_SEND
    } vpu_fetch_state_t;

    function automatic logic [BANK_W-1:0] get_bank_id(input logic [31:0] addr);
        return addr[10:9];
    endfunction

    function automatic logic [RADDR_W-1:0] get_raddr(input logic [31:0] addr);
        return addr[20:11];
    endfunction

    // Number of source operands an opcode reads; 0 marks an illegal opcode.
    function automatic logic [1:0] get_src_cnt(input logic [7:0] opcode);
        case (opcode)
            OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FMAX2, OP_FAVG2: return 2'd2;
            OP_FADD3, OP_FMAX3, OP_FAVG3:                          return 2'd3;
            OP_FSUM, OP_FMAX, OP_FEXP, OP_FSQRT, OP_FRECIP:        return 2'd1;
            default:                                               return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] get_src_addr(input vpu_h2d_req_instr_t instr, input int idx);
        case (idx)
            0:       return instr.src0;
            1:       return instr.src1;
            default: return instr.src2;
        endcase
    endfunction

endpackage

// File: rtl/vpu_operand_fetch.sv
// Operand-fetch stage between the VPU request FIFO and the vector lanes.
// Takes one instruction at a time, reads one SRAM row per source operand,
// then streams each row to the lanes as EXEC_CNT beats of BEAT_W bits.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   instr_valid_i/instr_ready_o      instruction handshake
//   instr_i                          vpu_h2d_req_instr_t
//   rd_en_o/rd_bank_o/rd_addr_o      per-port SRAM read request
//   rd_data_i                        per-port row data, one cycle after rd_en_o
//   op_valid_o/op_ready_i            lane beat handshake
//   op_data_o                        per-slot operand beat (slot i = src i)
//   op_src_mask_o                    valid operand slots
//   op_exec_idx_o/op_last_o          beat index / final beat
//   op_opcode_o/op_dst_o             sideband for execute/writeback
//   illegal_o                        one-cycle pulse on undefined opcode
module vpu_operand_fetch
    import vpu_operand_fetch_pkg::*;
#(
    parameter int SRC_CNT = SRC_OPERAND_CNT,
    parameter int ROW_W   = SRAM_DATA_WIDTH,
    parameter int BEAT_W  = DWIDTH_PER_EXEC
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              instr_valid_i,
    output logic                              instr_ready_o,
    input  vpu_h2d_req_instr_t                instr_i,
    output logic [SRC_CNT-1:0]                rd_en_o,
    output logic [SRC_CNT-1:0][BANK_W-1:0]    rd_bank_o,
    output logic [SRC_CNT-1:0][RADDR_W-1:0]   rd_addr_o,
    input  logic [SRC_CNT-1:0][ROW_W-1:0]     rd_data_i,
    output logic                              op_valid_o,
    input  logic                              op_ready_i,
    output logic [SRC_CNT-1:0][BEAT_W-1:0]    op_data_o,
    output logic [SRC_CNT-1:0]                op_src_mask_o,
    output logic                              op_exec_idx_o,
    output logic                              op_last_o,
    output logic [7:0]                        op_opcode_o,
    output logic [31:0]                       op_dst_o,
    output logic                              illegal_o
);

    vpu_fetch_state_t                 state;
    logic [7:0]                       opcode_q;
    logic [31:0]                      dst_q;
    logic [1:0]                       src_cnt_q;
    logic [SRC_CNT-1:0][ROW_W-1:0]    row_buf;
    logic                             exec_idx;
    logic [1:0]                       accept_cnt;

    assign accept_cnt = get_src_cnt(instr_i.opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH_IDLE;
            opcode_q      <= '0;
            dst_q         <= '0;
            src_cnt_q     <= '0;
            row_buf       <= '0;
            exec_idx      <= 1'b0;
            instr_ready_o <= 1'b1;
            op_valid_o    <= 1'b0;
            illegal_o     <= 1'b0;
            rd_en_o       <= '0;
            rd_bank_o     <= '0;
            rd_addr_o     <= '0;
        end else begin
            illegal_o <= 1'b0;
            case (state)
                FETCH_IDLE: begin
                    if (instr_valid_i) begin
                        if (accept_cnt == 2'd0) begin
                            // Illegal opcodes are dropped; latched sideband is left untouched.
                            illegal_o <= 1'b1;
                        end else begin
                            opcode_q      <= instr_i.opcode;
                            dst_q         <= instr_i.dst0;
                            src_cnt_q     <= accept_cnt;
                            instr_ready_o <= 1'b0;
                            state         <= FETCH_READ;
                            // Read request is registered here so it is on the pins during READ.
                            for (int i = 0; i < SRC_CNT; i++) begin
                                rd_en_o[i]   <= (i < int'(accept_cnt));
                                rd_bank_o[i] <= (i < int'(accept_cnt)) ?
                                                get_bank_id(get_src_addr(instr_i, i)) : '0;
                                rd_addr_o[i] <= (i < int'(accept_cnt)) ?
                                                get_raddr(get_src_addr(instr_i, i)) : '0;
                            end
                        end
                    end
                end
                FETCH_READ: begin
                    rd_en_o   <= '0;
                    rd_bank_o <= '0;
                    rd_addr_o <= '0;
                    state     <= FETCH_CAPT;
                end
                FETCH_CAPT: begin
                    for (int i = 0; i < SRC_CNT; i++)
                        row_buf[i] <= (i < int'(src_cnt_q)) ? rd_data_i[i] : '0;
                    exec_idx   <= 1'b0;
                    op_valid_o <= 1'b1;
                    state      <= FETCH_SEND;
                end
                FETCH_SEND: begin
                    if (op_ready_i) begin
                        if (exec_idx) begin
                            exec_idx      <= 1'b0;
                            op_valid_o    <= 1'b0;
                            instr_ready_o <= 1'b1;
                            state         <= FETCH_IDLE;
                        end else begin
                            exec_idx <= 1'b1;
                        end
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    // Beat mux: beat 0 is the low half of the row, beat 1 the high half.
    for (genvar g = 0; g < SRC_CNT; g++) begin : g_beat
        assign op_data_o[g] = exec_idx ? row_buf[g][ROW_W-1 -: BEAT_W] : row_buf[g][BEAT_W-1:0];
    end

    always_comb begin
        op_src_mask_o = '0;
        for (int i = 0; i < SRC_CNT; i++)
            op_src_mask_o[i] = (i < int'(src_cnt_q));
    end

    assign op_exec_idx_o = exec_idx;
    assign op_last_o     = op_valid_o & exec_idx;
    assign op_opcode_o   = opcode_q;
    assign op_dst_o      = dst_q;

endmodule

// File: tb/tb_vpu_operand_fetch.sv
module tb_vpu_operand_fetch;
    import vpu_operand_fetch_pkg::*;

    localparam int SRC  = 3;
    localparam int ROW  = 512;
    localparam int BEAT = 256;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       instr_valid_i;
    logic                       instr_ready_o;
    vpu_h2d_req_instr_t         instr_i;
    logic [SRC-1:0]             rd_en_o;
    logic [SRC-1:0][1:0]        rd_bank_o;
    logic [SRC-1:0][9:0]        rd_addr_o;
    logic [SRC-1:0][ROW-1:0]    rd_data_i;
    logic                       op_valid_o;
    logic                       op_ready_i;
    logic [SRC-1:0][BEAT-1:0]   op_data_o;
    logic [SRC-1:0]             op_src_mask_o;
    logic                       op_exec_idx_o;
    logic                       op_last_o;
    logic [7:0]                 op_opcode_o;
    logic [31:0]                op_dst_o;
    logic                       illegal_o;

    vpu_operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
        .rd_en_o(rd_en_o), .rd_bank_o(rd_bank_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i), .op_data_o(op_data_o),
        .op_src_mask_o(op_src_mask_o), .op_exec_idx_o(op_exec_idx_o), .op_last_o(op_last_o),
        .op_opcode_o(op_opcode_o), .op_dst_o(op_dst_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;
    int ill_cnt = 0;

    // SRAM contents indexed by {bank, row}
    logic [ROW-1:0] mem [0:4095];

    // SRAM read port: data appears one cycle after the strobe, junk otherwise
    always @(posedge clk)
        for (int i = 0; i < SRC; i++)
            rd_data_i[i] <= rd_en_o[i] ? mem[{rd_bank_o[i], rd_addr_o[i]}] : {16{32'hDEAD_BEEF}};

    always @(negedge clk) if (illegal_o) ill_cnt++;

    typedef struct {
        logic [SRC-1:0][BEAT-1:0] data;
        logic [2:0]               mask;
        logic                     idx;
        logic                     last;
        logic [7:0]               opc;
        logic [31:0]              dst;
    } beat_t;
    beat_t exp_q[$];

    task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int model_cnt(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h08, 8'h09: return 2;
            8'h05, 8'h06, 8'h07:                      return 3;
            8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E:        return 1;
            default:                                  return 0;
        endcase
    endfunction

    // Expected beats of an accepted instruction, straight from memory contents
    task automatic model_push(input vpu_h2d_req_instr_t ins);
        int n;
        logic [31:0] s [3];
        logic [ROW-1:0] rows [3];
        beat_t e;
        n = model_cnt(ins.opcode);
        if (n == 0) return;
        s[0] = ins.src0; s[1] = ins.src1; s[2] = ins.src2;
        for (int i = 0; i < 3; i++)
            rows[i] = (i < n) ? mem[{s[i][10:9], s[i][20:11]}] : '0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 3; i++) e.data[i] = rows[i][b*BEAT +: BEAT];
            e.mask = 3'((1 << n) - 1);
            e.idx  = (b == 1);
            e.last = (b == 1);
            e.opc  = ins.opcode;
            e.dst  = ins.dst0;
            exp_q.push_back(e);
        end
    endtask

    // Compare process: every presented beat must match the head of the model queue
    always @(negedge clk) begin
        if (rst_n && op_valid_o) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_beat: got valid=1 want no beat");
            end else begin
                chk("beat_data",   op_data_o,     exp_q[0].data);
                chk("beat_mask",   op_src_mask_o, exp_q[0].mask);
                chk("beat_idx",    op_exec_idx_o, exp_q[0].idx);
                chk("beat_last",   op_last_o,     exp_q[0].last);
                chk("beat_opcode", op_opcode_o,   exp_q[0].opc);
                chk("beat_dst",    op_dst_o,      exp_q[0].dst);
                if (op_ready_i) void'(exp_q.pop_front());
            end
        end else if (rst_n) begin
            chk("idle_last", op_last_o, 1'b0);
        end
    end

    // Offer one instruction; returns the cycle count at the negedge before the accepting edge
    task automatic issue(input vpu_h2d_req_instr_t ins, output int acc);
        int n = 0;
        @(posedge clk); #1;
        instr_i = ins;
        instr_valid_i = 1'b1;
        @(negedge clk);
        while (!instr_ready_o && n < 100) begin @(negedge clk); n++; end
        if (!instr_ready_o) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got ready=0 want 1");
        end
        acc = cyc;
        model_push(ins);
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!op_valid_o && n < 30);
        if (!op_valid_o) begin
            tests++; fails++;
            $display("FAIL valid_timeout: got valid=0 want 1");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(instr_ready_o && exp_q.size() == 0) && n < 60);
        chk("drain_idle", {instr_ready_o, 8'(exp_q.size())}, {1'b1, 8'd0});
    endtask

    vpu_h2d_req_instr_t ins;
    int t0, t1, n;
    logic [SRC-1:0][BEAT-1:0] snap;

    initial begin
        for (int a = 0; a < 4096; a++)
            for (int w = 0; w < 16; w++)
                mem[a][w*32 +: 32] = {4'hC, 12'(a), 8'h00, 8'(w)};
        mem[{2'd2, 10'd5}] = {128{4'hA}};
        mem[{2'd3, 10'd7}] = {128{4'h5}};
        mem[{2'd0, 10'd9}] = {{16{16'h1234}}, {16{16'h5678}}};

        instr_valid_i = 1'b0;
        instr_i       = '0;
        op_ready_i    = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready",  instr_ready_o, 1'b1);
        chk("rst_valid",  op_valid_o,    1'b0);
        chk("rst_rd_en",  rd_en_o,       3'b000);
        chk("rst_illegal", illegal_o,    1'b0);
        chk("rst_data",   op_data_o,     768'd0);
        chk("rst_side",   {op_src_mask_o, op_last_o, op_opcode_o, op_dst_o}, 44'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // FADD: two read ports, address split, mask and last flag
        ins = '{opcode: 8'h01, dst0: 32'h1111_2222, src0: 32'h0000_0A00,
                src1: 32'h0000_1200, src2: 32'h0000_0000};
        issue(ins, t0);
        @(negedge clk);
        chk("fadd_rd_en",  rd_en_o,   3'b011);
        chk("fadd_bank",   rd_bank_o, {2'd0, 2'd1, 2'd1});
        chk("fadd_row",    rd_addr_o, {10'd0, 10'd2, 10'd1});
        chk("fadd_ready",  instr_ready_o, 1'b0);
        wait_valid(n);
        chk("fadd_mask",   op_src_mask_o, 3'b011);
        chk("fadd_slot2",  op_data_o[2], 256'd0);
        chk("fadd_last0",  op_last_o, 1'b0);
        @(negedge clk);
        chk("fadd_last1",  op_last_o, 1'b1);
        wait_idle();

        // FADD3: latency and beat halves; ignored address bits set
        ins = '{opcode: 8'h05, dst0: 32'hCAFE_0005, src0: 32'hFFE0_2DFF,
                src1: 32'h0000_3E00, src2: 32'h0000_4800};
        issue(ins, t0);
        wait_valid(n);
        chk("fadd3_latency", n, 3);
        chk("fadd3_b0_s0", op_data_o[0], {64{4'hA}});
        chk("fadd3_b0_s2", op_data_o[2], {16{16'h5678}});
        @(negedge clk);
        chk("fadd3_b1_s1", op_data_o[1], {64{4'h5}});
        chk("fadd3_b1_s2", op_data_o[2], {16{16'h1234}});
        wait_idle();

        // FEXP with lane backpressure for 4 cycles on beat 0
        op_ready_i = 1'b0;
        ins = '{opcode: 8'h0C, dst0: 32'h0000_00EE, src0: 32'h0003_5E00,
                src1: 32'hFFFF_FFFF, src2: 32'hFFFF_FFFF};
        issue(ins, t0);
        wait_valid(n);
        snap = op_data_o;
        for (int k = 0; k < 4; k++) begin
            chk("bp_hold", {op_valid_o, op_exec_idx_o, op_src_mask_o, op_data_o},
                {1'b1, 1'b0, 3'b001, snap});
            if (k < 3) @(negedge clk);
        end
        @(posedge clk); #1;
        op_ready_i = 1'b1;
        wait_idle();

        // Illegal opcodes 0x00 and 0x0F
        ins = '{opcode: 8'h00, dst0: 32'h1, src0: 32'h0A00, src1: 32'h0, src2: 32'h0};
        issue(ins, t0);
        @(negedge clk);
        chk("ill0_pulse", {illegal_o, rd_en_o, instr_ready_o}, {1'b1, 3'b000, 1'b1});
        ins.opcode = 8'h0F;
        issue(ins, t0);
        @(negedge clk);
        chk("ill1_pulse", {illegal_o, rd_en_o, instr_ready_o}, {1'b1, 3'b000, 1'b1});
        @(negedge clk);
        chk("ill1_clear", {illegal_o, rd_en_o, instr_ready_o, op_valid_o}, {1'b0, 3'b000, 1'b1, 1'b0});

        // Back-to-back FMUL
        ins = '{opcode: 8'h03, dst0: 32'h0000_0300, src0: 32'h0000_0600,
                src1: 32'h0001_0200, src2: 32'h0};
        issue(ins, t0);
        ins.dst0 = 32'h0000_0301;
        ins.src0 = 32'h0002_0400;
        issue(ins, t1);
        chk("b2b_spacing", t1 - t0, 5);
        wait_idle();

        // Reset during CAPT abandons the instruction
        ins = '{opcode: 8'h02, dst0: 32'hDEAD_0002, src0: 32'h0000_0A00,
                src1: 32'h0000_1200, src2: 32'h0};
        issue(ins, t0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mrst_state", {instr_ready_o, op_valid_o, rd_en_o}, {1'b1, 1'b0, 3'b000});
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mrst_quiet", {instr_ready_o, op_valid_o}, {1'b1, 1'b0});
        end

        // Recovery after reset: single-source op
        ins = '{opcode: 8'h0A, dst0: 32'h0000_0A0A, src0: 32'h0000_0E00,
                src1: 32'h0, src2: 32'h0};
        issue(ins, t0);
        wait_valid(n);
        chk("fsum_latency", n, 3);
        wait_idle();

        chk("illegal_pulses", ill_cnt, 2);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
